// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a programmable, maskable
// N-bit pattern. It supports overlapping or non-overlapping detection and keeps
// a saturating match counter. The z pulse is registered, so it rises in the
// cycle after the sample that completes a match.
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1010,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             w,
    input  logic             load,
    input  logic [N-1:0]     pat_in,
    input  logic [N-1:0]     mask_in,
    output logic             z,
    output logic [CNT_W-1:0] count,
    output logic             armed
);

    localparam int               FILL_W    = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [N-1:0]      hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [N-1:0]      pat_q, pat_d;
    logic [N-1:0]      mask_q, mask_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              z_q, z_d;

    logic [N-1:0]      hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    // Match is judged on the history as it will look after this sample is shifted in.
    always_comb begin
        hist_shift = {hist_q[N-2:0], w};
        fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
        match      = (fill_inc == FILL_FULL) &&
                     (((hist_shift ^ pat_q) & mask_q) == '0);
    end

    // Next-state selection: load beats en; a w bit offered with load is dropped.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        count_d = count_q;
        z_d     = 1'b0;
        if (load) begin
            pat_d  = pat_in;
            mask_d = mask_in;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            z_d    = match;
            if (match) begin
                if (!OVERLAP) begin
                    // Non-overlapping mode forgets the history and needs N new bits.
                    fill_d = '0;
                end
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PATTERN;
            mask_q  <= '1;
            count_q <= '0;
            z_q     <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            z_q     <= z_d;
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        z     = z_q;
        count = count_q;
        armed = (fill_q == FILL_FULL);
    end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst, en, w, load;
    logic [N-1:0] pat_in, mask_in;

    logic z_a, z_b, z_c;
    logic armed_a, armed_b, armed_c;
    logic [7:0] count_a, count_b;
    logic [1:0] count_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // a: defaults (overlap), b: non-overlap, c: 2-bit counter
    seq_detector_param #(.N(N), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .w(w), .load(load), .pat_in(pat_in),
        .mask_in(mask_in), .z(z_a), .count(count_a), .armed(armed_a));
    seq_detector_param #(.N(N), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .en(en), .w(w), .load(load), .pat_in(pat_in),
        .mask_in(mask_in), .z(z_b), .count(count_b), .armed(armed_b));
    seq_detector_param #(.N(N), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .en(en), .w(w), .load(load), .pat_in(pat_in),
        .mask_in(mask_in), .z(z_c), .count(count_c), .armed(armed_c));

    // Reference model: the list of enabled bits since the last reset/load, and,
    // per instance, the index where its current detection window starts.
    bit          stream[$];
    int          start[3];
    bit          ovl[3]  = '{1'b1, 1'b0, 1'b1};
    int          cmax[3] = '{255, 255, 3};
    logic [N-1:0] m_pat;
    logic [N-1:0] m_mask;
    int          exp_cnt[3];
    logic        exp_z[3];

    function automatic bit model_hit(int i);
        int base;
        if (stream.size() - start[i] < N) return 1'b0;
        base = stream.size() - N;
        // Bit N-1 of the pattern is the oldest of the last N bits received.
        for (int k = 0; k < N; k++) begin
            if (m_mask[N-1-k] && (stream[base+k] != m_pat[N-1-k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_bit(input string tag, input logic act, input logic exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic b, input logic ld,
                        input logic [N-1:0] p, input logic [N-1:0] m);
        bit hit;
        rst = r; en = e; w = b; load = ld; pat_in = p; mask_in = m;
        @(posedge clk);
        if (r) begin
            stream.delete();
            m_pat  = 4'b1010;
            m_mask = '1;
            for (int i = 0; i < 3; i++) begin
                start[i] = 0; exp_cnt[i] = 0; exp_z[i] = 1'b0;
            end
        end else if (ld) begin
            stream.delete();
            m_pat  = p;
            m_mask = m;
            for (int i = 0; i < 3; i++) begin
                start[i] = 0; exp_z[i] = 1'b0;
            end
        end else if (e) begin
            stream.push_back(b);
            for (int i = 0; i < 3; i++) begin
                hit = model_hit(i);
                exp_z[i] = hit;
                if (hit) begin
                    if (exp_cnt[i] < cmax[i]) exp_cnt[i]++;
                    if (!ovl[i]) start[i] = stream.size();
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) exp_z[i] = 1'b0;
        end
        #1;
        check_bit("z_a", z_a, exp_z[0]);
        check_bit("z_b", z_b, exp_z[1]);
        check_bit("z_c", z_c, exp_z[2]);
        check_cnt("count_a", count_a, 8'(exp_cnt[0]));
        check_cnt("count_b", count_b, 8'(exp_cnt[1]));
        check_cnt("count_c", {6'b0, count_c}, 8'(exp_cnt[2]));
        check_bit("armed_a", armed_a, (stream.size() - start[0]) >= N);
        check_bit("armed_b", armed_b, (stream.size() - start[1]) >= N);
        check_bit("armed_c", armed_c, (stream.size() - start[2]) >= N);
    endtask

    task automatic send(input logic b);
        step(1'b0, 1'b1, b, 1'b0, '0, '0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; w = 1'b0; load = 1'b0; pat_in = '0; mask_in = '0;
        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        // Absolute reset-state checks against constants
        check_bit("reset_z", z_a, 1'b0);
        check_cnt("reset_count", count_a, 8'd0);
        check_bit("reset_armed", armed_a, 1'b0);

        // Default pattern 1010: overlap gives hits after bits 4 and 6, non-overlap after 4 and 8
        send(1); send(0); send(1); send(0);
        check_bit("dir_z_after4", z_a, 1'b1);
        send(1); send(0);
        check_bit("dir_z_after6_ovl", z_a, 1'b1);
        check_bit("dir_z_after6_novl", z_b, 1'b0);
        send(1); send(0);
        check_cnt("dir_count_novl", count_b, 8'd2);

        // en gaps between samples 2 and 3
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        send(1); send(0); idle(); idle(); idle(); send(1); send(0);
        check_bit("gap_z", z_a, 1'b1);
        check_cnt("gap_count", count_a, 8'd1);

        // Load 1100 with mask 1101 (bit 1 don't care); w offered with load is discarded
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, 4'b1101);
        check_cnt("load_count_hold", count_a, 8'd1);
        send(1); send(1); send(1); send(0);
        check_bit("mask_match", z_a, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 4'b1101);
        send(1); send(0); send(1); send(0);
        check_bit("mask_nomatch", z_a, 1'b0);

        // Pattern 1111 on eight ones: c saturates at 3
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 4'b1111);
        for (int k = 0; k < 8; k++) send(1);
        check_cnt("sat_count_c", {6'b0, count_c}, 8'd3);

        // All-zero mask: every full-history sample matches
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < 9; k++) send(k[0]);

        // Reset after 3 of 4 pattern bits, then the final bit
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        send(1); send(0); send(1);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        send(0);
        check_bit("rst_mid_z", z_a, 1'b0);
        send(1); send(0); send(1); send(0);
        check_bit("post_rst_match", z_a, 1'b1);

        // Randomized phase
        for (int t = 0; t < 600; t++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)
                step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
            else if (r < 7)
                step(1'b0, 1'($urandom), 1'($urandom), 1'b1, 4'($urandom), 4'($urandom));
            else
                step(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom), 1'b0,
                     4'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
